bus_cond_detector: RTL

BUS_COND_DETECTOR -- requirements
Module: bus_cond_detector

---
 rtl/bus_cond_detector.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/bus_cond_detector.sv
// -----------------------------------------------------------------------------
// bus_cond_detector
//
// Watches a raw two-wire (SCL/SDA) bus, synchronizes both lines into the
// i_clk_in domain and reports the bus conditions:
//   - single-cycle SCL rising / falling edge strobes,
//   - single-cycle START, repeated-START and STOP strobes,
//   - bus busy (between START and STOP) and bus free (idle long enough).
//
// Parameters
//   SYNC_STAGES      synchronizer flops per line (2..4)
//   BUS_FREE_CYCLES  consecutive idle (SCL=1, SDA=1) samples needed before the
//                    bus is declared free (1..255)
//
// Optional feature
//   BUS_COND_GLITCH_FILTER_EN  when defined, a 3-sample majority filter follows
//                              each synchronizer; single-sample pulses are
//                              suppressed and every output is 2 cycles later.
//
// Ports
//   i_clk_in        in   block clock, all logic on its rising edge
//   i_rst_n         in   synchronous active-low reset
//   i_scl, i_sda    in   raw asynchronous pin levels
//   o_scl_sync      out  synchronized (filtered) SCL level
//   o_sda_sync      out  synchronized (filtered) SDA level
//   o_scl_pos_edge  out  one-cycle strobe on SCL 0->1
//   o_scl_neg_edge  out  one-cycle strobe on SCL 1->0
//   o_start_det     out  one-cycle strobe on START while not busy
//   o_rstart_det    out  one-cycle strobe on START while busy
//   o_stop_det      out  one-cycle strobe on STOP while busy
//   o_bus_busy      out  high between START and STOP
//   o_bus_free      out  high once the bus has been idle long enough
// -----------------------------------------------------------------------------
module bus_cond_detector #(
    parameter int SYNC_STAGES     = 2,
    parameter int BUS_FREE_CYCLES = 26
) (
    input  logic i_clk_in,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_sync,
    output logic o_sda_sync,
    output logic o_scl_pos_edge,
    output logic o_scl_neg_edge,
    output logic o_start_det,
    output logic o_rstart_det,
    output logic o_stop_det,
    output logic o_bus_busy,
    output logic o_bus_free
);

    localparam logic [1:0] ST_WAIT_FREE = 2'd0;
    localparam logic [1:0] ST_FREE      = 2'd1;
    localparam logic [1:0] ST_BUSY      = 2'd2;

    localparam logic [7:0] FREE_LIMIT = 8'(BUS_FREE_CYCLES);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_cur;
    logic                   sda_cur;
    logic                   scl_prv_q;
    logic                   sda_prv_q;

    // -------------------------------------------------------------------------
    // Synchronizers: bit 0 takes the raw pin, the top bit is the settled sample.
    // -------------------------------------------------------------------------
    // NOTE: line flops reset to 1 (idle bus level), not 0, so that leaving
    // reset never looks like an SCL/SDA edge or a START/STOP condition.
    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
        end
    end

`ifdef BUS_COND_GLITCH_FILTER_EN
    // -------------------------------------------------------------------------
    // Majority of the newest synchronized sample and the two before it; a
    // level must persist for two samples before it reaches cur.
    // -------------------------------------------------------------------------
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
            scl_filt_q <= maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
            sda_filt_q <= maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_cur = scl_filt_q;
    assign sda_cur = sda_filt_q;
`else
    assign scl_cur = scl_sync_q[SYNC_STAGES-1];
    assign sda_cur = sda_sync_q[SYNC_STAGES-1];
`endif

    // Previous sample, so that every condition compares two consecutive samples.
    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            scl_prv_q <= 1'b1;
            sda_prv_q <= 1'b1;
        end else begin
            scl_prv_q <= scl_cur;
            sda_prv_q <= sda_cur;
        end
    end

    assign o_scl_sync = scl_cur;
    assign o_sda_sync = sda_cur;

    // -------------------------------------------------------------------------
    // Condition decode. Requiring SCL high in both samples excludes the case
    // where SCL and SDA move together, which then yields only an edge strobe.
    // -------------------------------------------------------------------------
    logic start_cond;
    logic stop_cond;
    logic line_idle;
    logic [7:0] cnt_inc;

    assign start_cond = scl_prv_q & scl_cur & sda_prv_q & ~sda_cur;
    assign stop_cond  = scl_prv_q & scl_cur & ~sda_prv_q & sda_cur;
    assign line_idle  = scl_cur & sda_cur;

    // -------------------------------------------------------------------------
    // Bus state machine
    // -------------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_d, rstart_d, stop_d;

    // Saturating increment; the counter never passes the free threshold.
    assign cnt_inc = (cnt_q >= FREE_LIMIT) ? cnt_q : cnt_q + 8'd1;

    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned (which would infer a latch); only blocking '=' is used here.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        rstart_d = 1'b0;
        stop_d   = 1'b0;

        case (state_q)
            ST_WAIT_FREE: begin
                if (start_cond) begin
                    // A START is honoured even before the free time expires.
                    state_d = ST_BUSY;
                    start_d = 1'b1;
                    cnt_d   = 8'd0;
                end else if (stop_cond) begin
                    cnt_d = 8'd0;
                end else if (line_idle) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FREE_LIMIT) begin
                        state_d = ST_FREE;
                    end
                end else begin
                    cnt_d = 8'd0;
                end
            end

            ST_FREE: begin
                if (start_cond) begin
                    state_d = ST_BUSY;
                    start_d = 1'b1;
                    cnt_d   = 8'd0;
                end else if (!line_idle) begin
                    state_d = ST_WAIT_FREE;
                    cnt_d   = 8'd0;
                end
            end

            ST_BUSY: begin
                if (start_cond) begin
                    rstart_d = 1'b1;
                end else if (stop_cond) begin
                    state_d = ST_WAIT_FREE;
                    stop_d  = 1'b1;
                    cnt_d   = 8'd0;
                end
            end

            default: begin
                state_d = ST_WAIT_FREE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking '<=' only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            state_q        <= ST_WAIT_FREE;
            cnt_q          <= 8'd0;
            o_scl_pos_edge <= 1'b0;
            o_scl_neg_edge <= 1'b0;
            o_start_det    <= 1'b0;
            o_rstart_det   <= 1'b0;
            o_stop_det     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            o_scl_pos_edge <= ~scl_prv_q & scl_cur;
            o_scl_neg_edge <= scl_prv_q & ~scl_cur;
            o_start_det    <= start_d;
            o_rstart_det   <= rstart_d;
            o_stop_det     <= stop_d;
        end
    end

    assign o_bus_busy = (state_q == ST_BUSY);
    assign o_bus_free = (state_q == ST_FREE);

endmodule
